fifo_push_skid: RTL and testbench

- Write-side adapter placed in front of the standard FIFO's push port; the producer-side counterpart of the first-word-fall-through read wrapper.
- Accepts a valid/ready stream from a producer and issues `push`/`data_out` into the FIFO, driven by the FIFO's `full` flag.
- Uses a 2-entry skid buffer, so `in_ready` is a flop output and never combinational on `full`.
- This breaks the full-to-producer timing path in the accelerator's buffering datapaths.

---
 rtl/fifo_push_skid.sv | 166 ++++++++++++++++
 tb/tb_fifo_push_skid.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_skid.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_push_skid
//  Purpose  : Write-side adapter in front of a FIFO push port. Accepts a
//             valid/ready stream and issues push/data_out into the FIFO,
//             throttled by the FIFO's full flag. A 2-entry skid buffer
//             keeps in_ready a pure flop output, so the FIFO's full flag
//             never reaches the producer combinationally.
//  Ports    : clk, rst (async, active-high)  - clock and hard reset
//             Reset                           - synchronous soft clear
//             in_valid/in_data/in_ready       - producer stream
//             push/data_out/full              - FIFO push interface
//             occupancy[1:0]                  - words held (0..2)
//             push_cnt/stall_cnt              - statistics (optional)
//  Options  : define FIFO_PUSH_SKID_STAT_EN to add the saturating
//             push_cnt/stall_cnt counters and the STAT_WIDTH parameter.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_push_skid #(
  parameter int DATA_WIDTH = 4
`ifdef FIFO_PUSH_SKID_STAT_EN
  ,
  parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  full,
  output logic [1:0]            occupancy
`ifdef FIFO_PUSH_SKID_STAT_EN
  ,
  output logic [STAT_WIDTH-1:0] push_cnt,
  output logic [STAT_WIDTH-1:0] stall_cnt
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q,  head_d;
  logic [DATA_WIDTH-1:0] skid_q,  skid_d;
  logic                  in_ready_q, in_ready_d;

  logic                  w_accept;
  logic                  w_drain;

  assign w_accept = in_valid && in_ready_q;
  // Drain is combinational from state and full; it is the push strobe.
  assign w_drain  = (state_q != S_EMPTY) && !full;

  assign push      = w_drain;
  assign data_out  = head_q;
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (Reset) begin
      // Soft clear dominates any simultaneous accept or drain.
      state_d = S_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            state_d = S_ONE;
            head_d  = in_data;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            head_d = in_data;
          end else if (w_accept) begin
            state_d = S_TWO;
            skid_d  = in_data;
          end else if (w_drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (w_drain) begin
            state_d = S_ONE;
            head_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end

    // Registering the look-ahead makes in_ready drop in the same cycle
    // the adapter becomes full, so no accepted word can ever be lost.
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef FIFO_PUSH_SKID_STAT_EN
  logic [STAT_WIDTH-1:0] push_cnt_q,  push_cnt_d;
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                  w_stall;

  assign w_stall = (state_q != S_EMPTY) && full;

  always_comb begin
    push_cnt_d  = push_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (Reset) begin
      push_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      // Both counters stick at all-ones instead of wrapping.
      if (w_drain && (push_cnt_q != {STAT_WIDTH{1'b1}})) begin
        push_cnt_d = push_cnt_q + 1'b1;
      end
      if (w_stall && (stall_cnt_q != {STAT_WIDTH{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign push_cnt  = push_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_push_skid
//  Purpose  : Scoreboard bench for fifo_push_skid. Accepted words are queued
//             by a cycle model of the adapter; a negedge monitor pops and
//             compares on every push and checks in_ready/occupancy/push.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_push_skid;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          Reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          push;
  logic [DW-1:0] data_out;
  logic          full;
  logic [1:0]    occupancy;
`ifdef FIFO_PUSH_SKID_STAT_EN
  logic [15:0]   push_cnt;
  logic [15:0]   stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fifo_push_skid #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .push      (push),
    .data_out  (data_out),
    .full      (full),
    .occupancy (occupancy)
`ifdef FIFO_PUSH_SKID_STAT_EN
    ,
    .push_cnt  (push_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard producer ----------------
  logic [DW-1:0] expq[$];
  int            m_cnt      = 0;
  logic          m_ready    = 1'b1;
  logic          m_acc_last = 1'b0;
  logic [15:0]   m_pc       = '0;
  logic [15:0]   m_sc       = '0;
  logic          m_acc;
  logic          m_drn;

  assign m_acc = in_valid && m_ready;
  assign m_drn = (m_cnt != 0) && !full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt      <= 0;
      m_ready    <= 1'b1;
      m_acc_last <= 1'b0;
      m_pc       <= '0;
      m_sc       <= '0;
      expq.delete();
    end else begin
      m_acc_last <= m_acc;
      if (Reset) begin
        m_cnt   <= 0;
        m_ready <= 1'b1;
        m_pc    <= '0;
        m_sc    <= '0;
        expq.delete();
      end else begin
        if (m_acc) expq.push_back(in_data);
        m_cnt   <= m_cnt + int'(m_acc) - int'(m_drn);
        m_ready <= ((m_cnt + int'(m_acc) - int'(m_drn)) != 2);
        if (m_drn && m_pc != 16'hFFFF) m_pc <= m_pc + 16'd1;
        if ((m_cnt != 0) && full && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard consumer ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("occupancy", {30'd0, occupancy}, m_cnt);
    chk("push", {31'd0, push}, {31'd0, m_drn});
    if (push === 1'b1) begin
      if (expq.size() == 0) begin
        chk("push_unexpected", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("data_out", {28'd0, data_out}, {28'd0, e});
      end
    end
`ifdef FIFO_PUSH_SKID_STAT_EN
    chk("push_cnt", {16'd0, push_cnt}, {16'd0, m_pc});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_sc});
`endif
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (m_acc_last) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_push"}, {31'd0, push}, 32'd0);
    chk({tag, "_occupancy"}, {30'd0, occupancy}, 32'd0);
    chk({tag, "_data_out"}, {28'd0, data_out}, 32'd0);
`ifdef FIFO_PUSH_SKID_STAT_EN
    chk({tag, "_push_cnt"}, {16'd0, push_cnt}, 32'd0);
    chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
`endif
  endtask

  logic tog_done;

  initial begin
    rst      = 1'b1;
    Reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    full     = 1'b0;
    tog_done = 1'b0;

    idle(2);
    chk_reset_outputs("por");
    rst = 1'b0;
    idle(1);

    // single word, 1-cycle latency
    send(4'h5);
    idle(3);

    // back-to-back stream, in_ready must stay high
    for (int i = 1; i <= 8; i++) send(DW'(i));
    idle(3);

    // backpressure: fill to TWO, hold, then release
    full = 1'b1;
    fork
      begin
        send(4'hA);
        send(4'hB);
        chk("bp_occupancy", {30'd0, occupancy}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        send(4'hC);
      end
      begin
        idle(8);
        full = 1'b0;
      end
    join
    idle(4);

    // full toggling every cycle with random traffic
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) != 0) send(DW'($urandom_range(0, 15)));
          else idle(1);
        end
        tog_done = 1'b1;
      end
      begin
        while (!tog_done) begin
          @(posedge clk);
          #1;
          full = ~full;
        end
      end
    join
    full = 1'b0;
    idle(4);

    // sync Reset while holding two words
    full = 1'b1;
    send(4'h6);
    send(4'h7);
    chk("two_occupancy", {30'd0, occupancy}, 32'd2);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    full  = 1'b0;
    chk_reset_outputs("srst");
    send(4'h3);
    idle(3);

    // async rst pulse mid-stream, off the clock edge
    fork
      begin
        for (int i = 0; i < 10; i++) send(DW'(i + 9));
      end
      begin
        full = 1'b1;
        idle(2);
        full = 1'b0;
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        #9;
        rst = 1'b0;
      end
    join
    idle(6);

    chk("drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
